ifu_fetch: RTL

- Instruction fetch unit sitting directly upstream of the decode/execute datapath.
- Owns the architectural PC and issues single-outstanding 64-bit read requests on a valid/ready memory bus.
- Selects the 32-bit instruction word from each response and presents it, with its PC, to decode through a valid/ready handshake.
- Accepts redirects (branch/jump dnpc) from execute and discards stale in-flight responses.

---
 rtl/ifu_fetch_pkg.sv | 16 +
 rtl/ifu_fetch_word_sel.sv | 13 +
 rtl/ifu_fetch.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// State encoding is 3 bits to match the existing decode-side debug views.
package ifu_fetch_pkg;

    localparam logic [63:0] IFU_PC_INIT  = 64'h8000_0000;
    localparam int          IFU_INST_LEN = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_DROP = 3'd4
    } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_word_sel.sv
// Picks the 32-bit instruction half of a 64-bit fetch beat and flags a PC
// that is not 4-byte aligned.
module ifu_word_sel (
    input  logic [2:0]  pc_lo,
    input  logic [63:0] data,
    output logic [31:0] word,
    output logic        misaligned
);

    assign word       = pc_lo[2] ? data[63:32] : data[31:0];
    assign misaligned = (pc_lo[1:0] != 2'b00);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, issues one outstanding 64-bit read at a time,
// hands the selected word to decode, and discards responses made stale by redirects.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] PC_INIT  = XLEN'(IFU_PC_INIT),
    parameter int              INST_LEN = IFU_INST_LEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [63:0]     mem_resp_data,
    input  logic            mem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
);

    ifu_state_e      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            drop;
    logic            enter_req;
    logic [31:0]     sel_word;
    logic            npc_misaligned;

    // npc is the value pc takes this edge; redirect always beats the sequential step.
    always_comb begin
        npc = pc;
        if (redirect_valid)
            npc = redirect_pc;
        else if (state == S_OUT && inst_ready)
            npc = pc + XLEN'(INST_LEN);
    end

    always_comb begin
        enter_req = 1'b0;
        case (state)
            S_IDLE:  enter_req = !redirect_valid;
            S_REQ:   enter_req = !mem_req_valid && redirect_valid;
            S_WAIT:  enter_req = mem_resp_valid && redirect_valid;
            S_OUT:   enter_req = redirect_valid || inst_ready;
            S_DROP:  enter_req = mem_resp_valid;
            default: enter_req = 1'b0;
        endcase
    end

    // In S_WAIT a response is only kept without a redirect, so npc equals pc there.
    ifu_word_sel u_word_sel (
        .pc_lo      (npc[2:0]),
        .data       (mem_resp_data),
        .word       (sel_word),
        .misaligned (npc_misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            pc            <= PC_INIT;
            drop          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= {PC_INIT[XLEN-1:3], 3'b000};
            inst_valid    <= 1'b0;
            inst          <= 32'h0;
            inst_pc       <= '0;
            inst_fault    <= 1'b0;
        end else begin
            pc <= npc;
            case (state)
                S_IDLE, S_DROP: ;
                S_REQ: begin
                    // A misaligned entry never raised mem_req_valid; it becomes a faulting slot.
                    if (!mem_req_valid) begin
                        if (!redirect_valid) begin
                            state      <= S_OUT;
                            inst_valid <= 1'b1;
                            inst       <= 32'h0;
                            inst_pc    <= pc;
                            inst_fault <= 1'b1;
                        end
                    end else if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        drop          <= 1'b0;
                        state         <= (redirect_valid || drop) ? S_DROP : S_WAIT;
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!redirect_valid) begin
                        if (mem_resp_valid) begin
                            state      <= S_OUT;
                            inst_valid <= 1'b1;
                            inst       <= sel_word;
                            inst_pc    <= pc;
                            inst_fault <= mem_resp_err;
                        end
                    end else if (!mem_resp_valid) begin
                        state <= S_DROP;
                    end
                end
                S_OUT: if (enter_req) inst_valid <= 1'b0;
                default: state <= S_IDLE;
            endcase

            if (enter_req) begin
                state         <= S_REQ;
                mem_req_valid <= !npc_misaligned;
                mem_req_addr  <= {npc[XLEN-1:3], 3'b000};
            end
        end
    end

endmodule
